// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: Mealy match strobe on the bit that completes
// a run-time loadable pattern, with a registered strobe and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned              PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0]   PATTERN     = 4'b1101,
  parameter bit                       OVERLAP     = 1'b1,
  parameter int unsigned              CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   pattern_load,
  input  logic [PATTERN_LEN-1:0] pattern_in,
  input  logic                   en,
  input  logic                   i,
  output logic                   match,
  output logic                   match_q,
  output logic [CNT_WIDTH-1:0]   match_count,
  output logic                   sat
);

  localparam int unsigned FILL_W = $clog2(PATTERN_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PATTERN_LEN - 1);

  logic [PATTERN_LEN-1:0] r_pat;
  logic [PATTERN_LEN-1:0] r_hist;
  logic [FILL_W-1:0]      r_fill;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   r_sat;
  logic                   r_match_q;

  logic [PATTERN_LEN-1:0] w_cand;
  logic                   w_match;
  logic                   w_cnt_full;

  // The incoming bit completes the candidate window; only L-1 stored bits need be valid.
  assign w_cand     = {r_hist[PATTERN_LEN-2:0], i};
  assign w_match    = en & ~clear & ~pattern_load & (r_fill >= FILL_ARM) & (w_cand == r_pat);
  assign w_cnt_full = &r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pat  <= PATTERN;
      r_hist <= '0;
      r_fill <= '0;
    end else if (clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (pattern_load) begin
      r_pat  <= pattern_in;
      r_hist <= '0;
      r_fill <= '0;
    end else if (en) begin
      r_hist <= w_cand;
      if (w_match && !OVERLAP) begin
        r_fill <= '0;
      end else if (r_fill != FILL_FULL) begin
        r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count   <= '0;
      r_sat     <= 1'b0;
      r_match_q <= 1'b0;
    end else begin
      r_match_q <= w_match;
      if (clear) begin
        r_count <= '0;
        r_sat   <= 1'b0;
      end else if (w_match) begin
        if (w_cnt_full) begin
          r_sat <= 1'b1;
        end else begin
          r_count <= r_count + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign match       = w_match;
  assign match_q     = r_match_q;
  assign match_count = r_count;
  assign sat         = r_sat;

endmodule
